// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer.
// Gates decoder write strobes into their legal phase.
module core_sequencer #(
   parameter int OPW  = 4,
   parameter int CNTW = 16,
   parameter int TMO  = 15
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            Start,
   input  logic            Stop,
   input  logic [OPW-1:0]  Opcode,
   input  logic            InstrAck,
   input  logic            MemAck,
   output logic            InstrReq,
   output logic            IrLoad,
   output logic            MemReq,
   output logic            MemWe,
   output logic            RegWrEn,
   output logic            PcEn,
   output logic            Busy,
   output logic            Halted,
   output logic            Fault,
   output logic [CNTW-1:0] Retired
);

   localparam int TW = 8;
   localparam logic [OPW-1:0] OP_JMAX = OPW'(4);
   localparam logic [OPW-1:0] OP_STR  = OPW'(7);
   localparam logic [OPW-1:0] OP_LD   = OPW'(8);
   localparam logic [OPW-1:0] OP_RSV  = OPW'(9);
   localparam logic [OPW-1:0] OP_HALT = OPW'(11);
   localparam logic [OPW-1:0] OP_CMP  = OPW'(12);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TMO - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC,
      S_MEM, S_WB, S_HALTED, S_FAULT
   } state_t;

   state_t          state_q, state_d;
   logic [OPW-1:0]  op_q, op_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [CNTW-1:0] ret_q, ret_d;
   logic            is_mem, wb_wr;

   assign is_mem = (op_q == OP_LD) || (op_q == OP_STR);
   assign wb_wr  = !((op_q <= OP_JMAX) || (op_q == OP_STR) ||
                     (op_q == OP_RSV) || (op_q == OP_CMP));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         tmo_q   <= '0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         tmo_q   <= tmo_d;
         ret_q   <= ret_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      tmo_d   = tmo_q;
      ret_d   = ret_q;
      unique case (state_q)
         S_IDLE:   if (Start) state_d = S_FETCH;
         S_FETCH: begin
            if (InstrAck) begin
               op_d    = Opcode;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (op_q == OP_HALT) begin
               state_d = S_HALTED;
               ret_d   = ret_q + 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_mem) begin
               state_d = S_MEM;
               tmo_d   = '0;
            end else begin
               state_d = S_WB;
            end
         end
         // MemAck beats a timeout landing on the same cycle
         S_MEM: begin
            tmo_d = tmo_q + 1'b1;
            if (MemAck)                 state_d = S_WB;
            else if (tmo_q == TMO_LAST) state_d = S_FAULT;
         end
         S_WB: begin
            ret_d   = ret_q + 1'b1;
            state_d = Stop ? S_IDLE : S_FETCH;
         end
         S_HALTED: if (Start) state_d = S_FETCH;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      InstrReq = 1'b0;
      IrLoad   = 1'b0;
      MemReq   = 1'b0;
      MemWe    = 1'b0;
      RegWrEn  = 1'b0;
      PcEn     = 1'b0;
      Halted   = 1'b0;
      Fault    = 1'b0;
      unique case (state_q)
         S_FETCH:  InstrReq = 1'b1;
         S_DECODE: IrLoad   = 1'b1;
         S_MEM: begin
            MemReq = 1'b1;
            MemWe  = (op_q == OP_STR);
         end
         S_WB: begin
            PcEn    = 1'b1;
            RegWrEn = wb_wr;
         end
         S_HALTED: Halted = 1'b1;
         S_FAULT:  Fault  = 1'b1;
         default: ;
      endcase
   end

   assign Busy = (state_q != S_IDLE) && (state_q != S_HALTED) &&
                 (state_q != S_FAULT);
   assign Retired = ret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer.
// Writeback expectations are queued at issue and popped at PcEn.
module tb_core_sequencer;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Start = 1'b0;
   logic       Stop = 1'b0;
   logic       InstrAck = 1'b0;
   logic       MemAck = 1'b0;
   logic [3:0] Opcode = 4'd0;
   logic       InstrReq, IrLoad, MemReq, MemWe, RegWrEn, PcEn;
   logic       Busy, Halted, Fault;
   logic [15:0] Retired;
   logic       ir4, il4, mr4, mw4, rw4, pc4, b4, h4, f4;
   logic [3:0] Retired4;

   core_sequencer #(.OPW(4), .CNTW(16), .TMO(15)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stop(Stop),
      .Opcode(Opcode), .InstrAck(InstrAck), .MemAck(MemAck),
      .InstrReq(InstrReq), .IrLoad(IrLoad), .MemReq(MemReq),
      .MemWe(MemWe), .RegWrEn(RegWrEn), .PcEn(PcEn), .Busy(Busy),
      .Halted(Halted), .Fault(Fault), .Retired(Retired)
   );

   core_sequencer #(.OPW(4), .CNTW(4), .TMO(15)) dut4 (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stop(Stop),
      .Opcode(Opcode), .InstrAck(InstrAck), .MemAck(MemAck),
      .InstrReq(ir4), .IrLoad(il4), .MemReq(mr4),
      .MemWe(mw4), .RegWrEn(rw4), .PcEn(pc4), .Busy(b4),
      .Halted(h4), .Fault(f4), .Retired(Retired4)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        rw;
      logic [15:0] ret;
   } wb_t;

   wb_t         exp_q[$];
   wb_t         mon_e;
   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] model_ret = 16'd0;

   always @(negedge Clk) begin
      if (Reset_n) begin
         if (PcEn) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL wb_unexpected: PcEn with no queued instr");
            end else begin
               mon_e = exp_q.pop_front();
               if (RegWrEn !== mon_e.rw || Retired !== mon_e.ret) begin
                  miscompares++;
                  $display("FAIL wb: RegWrEn=%b Retired=%0d need %b %0d",
                           RegWrEn, Retired, mon_e.rw, mon_e.ret);
               end
            end
         end
         if (RegWrEn || MemWe) begin
            vectors++;
            if ((RegWrEn && MemWe) || (RegWrEn && !PcEn)) begin
               miscompares++;
               $display("FAIL strobes: RegWrEn=%b MemWe=%b PcEn=%b",
                        RegWrEn, MemWe, PcEn);
            end
         end
      end
   end

   task automatic issue(input logic rw);
      wb_t e;
      e.rw  = rw;
      e.ret = model_ret;
      exp_q.push_back(e);
      model_ret++;
   endtask

   task automatic run_instr(
      input  logic [3:0] op, input int iw, input int mw,
      output int cyc, output int nreq, output int nwe,
      output int nrw, output int npc, output int ir_at,
      output int pc_at);
      int fw, mc, guard;
      bit done;
      cyc = 0; nreq = 0; nwe = 0; nrw = 0; npc = 0;
      ir_at = 0; pc_at = 0; fw = 0; mc = 0; guard = 0; done = 0;
      Start = 1'b1;
      while (!done && guard < 300) begin
         @(negedge Clk);
         guard++;
         if (Busy) begin Start = 1'b0; cyc++; end
         if (IrLoad) ir_at = cyc;
         if (MemReq) nreq++;
         if (MemWe) nwe++;
         if (RegWrEn) nrw++;
         if (PcEn) begin npc++; pc_at = cyc; end
         InstrAck = 1'b0;
         MemAck   = 1'b0;
         if (InstrReq) begin
            if (fw < iw) fw++;
            else begin InstrAck = 1'b1; Opcode = op; end
         end
         if (MemReq) begin
            mc++;
            if (mc > mw) MemAck = 1'b1;
         end
         if (PcEn || Halted || Fault) done = 1;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL run_timeout: op=%b never completed", op);
      end
   endtask

   task automatic check_ret(input string tag);
      @(negedge Clk);
      vectors++;
      if (Retired !== model_ret) begin
         miscompares++;
         $display("FAIL %s_retired: got %0d need %0d",
                  tag, Retired, model_ret);
      end
   endtask

   task automatic test_reset;
      Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      vectors++;
      if ({InstrReq, IrLoad, MemReq, MemWe, RegWrEn, PcEn, Busy,
           Halted, Fault} !== 9'd0 || Retired !== 16'd0) begin
         miscompares++;
         $display("FAIL reset: outs=%b Retired=%0d need 0 0",
                  {InstrReq, IrLoad, MemReq, MemWe, RegWrEn, PcEn,
                   Busy, Halted, Fault}, Retired);
      end
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_add;
      int c, q, w, r, p, ia, pa;
      issue(1'b1);
      run_instr(4'b0101, 0, 0, c, q, w, r, p, ia, pa);
      vectors++;
      if (c !== 4 || ia !== 2 || pa !== 4 || r !== 1 || p !== 1 ||
          q !== 0) begin
         miscompares++;
         $display("FAIL add: cyc=%0d ir=%0d pc=%0d rw=%0d req=%0d need 4 2 4 1 0",
                  c, ia, pa, r, q);
      end
      check_ret("add");
   endtask

   task automatic test_back_to_back;
      int c, q, w, r, p, ia, pa;
      for (int k = 0; k < 3; k++) begin
         issue(1'b1);
         run_instr(4'b0101, 0, 0, c, q, w, r, p, ia, pa);
         vectors++;
         if (c !== 4 || pa !== 4) begin
            miscompares++;
            $display("FAIL b2b%0d: cyc=%0d pc=%0d need 4 4", k, c, pa);
         end
      end
      check_ret("b2b");
   endtask

   task automatic test_ld;
      int c, q, w, r, p, ia, pa;
      issue(1'b1);
      run_instr(4'b1000, 0, 3, c, q, w, r, p, ia, pa);
      vectors++;
      if (c !== 8 || q !== 4 || w !== 0 || r !== 1 || p !== 1) begin
         miscompares++;
         $display("FAIL ld: cyc=%0d req=%0d we=%0d rw=%0d need 8 4 0 1",
                  c, q, w, r);
      end
   endtask

   task automatic test_str;
      int c, q, w, r, p, ia, pa;
      issue(1'b0);
      run_instr(4'b0111, 0, 0, c, q, w, r, p, ia, pa);
      vectors++;
      if (c !== 5 || q !== 1 || w !== 1 || r !== 0 || p !== 1) begin
         miscompares++;
         $display("FAIL str: cyc=%0d req=%0d we=%0d rw=%0d pc=%0d need 5 1 1 0 1",
                  c, q, w, r, p);
      end
   endtask

   task automatic test_no_regwr;
      int c, q, w, r, p, ia, pa;
      logic [3:0] ops [3] = '{4'b0010, 4'b1100, 4'b1001};
      for (int k = 0; k < 3; k++) begin
         issue(1'b0);
         run_instr(ops[k], 0, 0, c, q, w, r, p, ia, pa);
         vectors++;
         if (c !== 4 || r !== 0 || p !== 1) begin
            miscompares++;
            $display("FAIL noreg_%b: cyc=%0d rw=%0d pc=%0d need 4 0 1",
                     ops[k], c, r, p);
         end
      end
      check_ret("noreg");
   endtask

   task automatic test_fetch_wait;
      int c, q, w, r, p, ia, pa;
      issue(1'b1);
      run_instr(4'b1101, 2, 0, c, q, w, r, p, ia, pa);
      vectors++;
      if (c !== 6 || ia !== 4 || r !== 1) begin
         miscompares++;
         $display("FAIL fetch_wait: cyc=%0d ir=%0d rw=%0d need 6 4 1",
                  c, ia, r);
      end
   endtask

   task automatic test_ack_at_timeout;
      int c, q, w, r, p, ia, pa;
      issue(1'b1);
      run_instr(4'b1000, 0, 14, c, q, w, r, p, ia, pa);
      vectors++;
      if (c !== 19 || q !== 15 || p !== 1 || Fault !== 1'b0) begin
         miscompares++;
         $display("FAIL ack_at_tmo: cyc=%0d req=%0d pc=%0d fault=%b need 19 15 1 0",
                  c, q, p, Fault);
      end
   endtask

   task automatic test_halt;
      int c, q, w, r, p, ia, pa;
      model_ret++;
      run_instr(4'b1011, 0, 0, c, q, w, r, p, ia, pa);
      vectors++;
      if (c !== 2 || p !== 0 || Halted !== 1'b1 || Busy !== 1'b0 ||
          Retired !== model_ret) begin
         miscompares++;
         $display("FAIL halt: cyc=%0d pc=%0d halted=%b busy=%b ret=%0d need 2 0 1 0 %0d",
                  c, p, Halted, Busy, Retired, model_ret);
      end
      repeat (3) @(negedge Clk);
      vectors++;
      if (Halted !== 1'b1 || Retired !== model_ret) begin
         miscompares++;
         $display("FAIL halt_hold: halted=%b ret=%0d need 1 %0d",
                  Halted, Retired, model_ret);
      end
      issue(1'b1);
      run_instr(4'b0101, 0, 0, c, q, w, r, p, ia, pa);
      vectors++;
      if (Halted !== 1'b0 || c !== 4) begin
         miscompares++;
         $display("FAIL halt_resume: halted=%b cyc=%0d need 0 4",
                  Halted, c);
      end
   endtask

   task automatic test_stop;
      int c, q, w, r, p, ia, pa;
      fork
         begin
            repeat (10) begin
               @(negedge Clk);
               if (IrLoad) break;
            end
            @(negedge Clk);
            Stop = 1'b1;
         end
      join_none
      issue(1'b1);
      run_instr(4'b0110, 0, 0, c, q, w, r, p, ia, pa);
      vectors++;
      if (c !== 4 || p !== 1 || Stop !== 1'b1) begin
         miscompares++;
         $display("FAIL stop_wb: cyc=%0d pc=%0d stop=%b need 4 1 1",
                  c, p, Stop);
      end
      check_ret("stop");
      repeat (3) @(negedge Clk);
      vectors++;
      if (Busy !== 1'b0 || InstrReq !== 1'b0) begin
         miscompares++;
         $display("FAIL stop_idle: busy=%b ireq=%b need 0 0",
                  Busy, InstrReq);
      end
      Stop = 1'b0;
   endtask

   task automatic test_wrap;
      int c, q, w, r, p, ia, pa;
      while (model_ret[3:0] != 4'd0) begin
         issue(1'b1);
         run_instr(4'b0101, 0, 0, c, q, w, r, p, ia, pa);
      end
      check_ret("wrap");
      vectors++;
      if (Retired4 !== 4'd0) begin
         miscompares++;
         $display("FAIL wrap4: got %0d need 0", Retired4);
      end
      issue(1'b1);
      run_instr(4'b0101, 0, 0, c, q, w, r, p, ia, pa);
      @(negedge Clk);
      vectors++;
      if (Retired4 !== 4'd1) begin
         miscompares++;
         $display("FAIL wrap4_next: got %0d need 1", Retired4);
      end
   endtask

   task automatic test_reset_mid_mem;
      int guard;
      guard = 0;
      Start  = 1'b1;
      Opcode = 4'b1000;
      while (!MemReq && guard < 20) begin
         @(negedge Clk);
         guard++;
         if (Busy) Start = 1'b0;
         InstrAck = InstrReq;
      end
      InstrAck = 1'b0;
      vectors++;
      if (MemReq !== 1'b1 || Retired === 16'd0) begin
         miscompares++;
         $display("FAIL pre_reset: memreq=%b ret=%0d need 1 nonzero",
                  MemReq, Retired);
      end
      Reset_n = 1'b0;
      #1;
      vectors++;
      if ({InstrReq, IrLoad, MemReq, MemWe, RegWrEn, PcEn, Busy,
           Halted, Fault} !== 9'd0 || Retired !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_mid_mem: outs=%b ret=%0d need 0 0",
                  {InstrReq, IrLoad, MemReq, MemWe, RegWrEn, PcEn,
                   Busy, Halted, Fault}, Retired);
      end
      model_ret = 16'd0;
      exp_q.delete();
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_fault;
      int c, q, w, r, p, ia, pa;
      run_instr(4'b1000, 0, 1000, c, q, w, r, p, ia, pa);
      vectors++;
      if (q !== 15 || p !== 0 || Fault !== 1'b1 || Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL fault: req=%0d pc=%0d fault=%b busy=%b need 15 0 1 0",
                  q, p, Fault, Busy);
      end
      Start = 1'b1;
      repeat (4) @(negedge Clk);
      vectors++;
      if (Fault !== 1'b1 || InstrReq !== 1'b0 || Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL fault_sticky: fault=%b ireq=%b busy=%b need 1 0 0",
                  Fault, InstrReq, Busy);
      end
      Start   = 1'b0;
      Reset_n = 1'b0;
      @(negedge Clk);
      vectors++;
      if (Fault !== 1'b0 || Retired !== 16'd0) begin
         miscompares++;
         $display("FAIL fault_reset: fault=%b ret=%0d need 0 0",
                  Fault, Retired);
      end
      Reset_n = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_ld();
      test_str();
      test_no_regwr();
      test_fetch_wait();
      test_ack_at_timeout();
      test_halt();
      test_stop();
      test_wrap();
      test_reset_mid_mem();
      test_fault();
      @(negedge Clk);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle sequencer for the 4-bit-opcode datapath.
- Steps each instruction through fetch, decode, execute, optional memory and writeback phases.
- Gates the combinational control decoder's write enables so register-file, memory and PC updates happen only in the correct phase.
- Handles instruction/data memory handshakes, halt, stop, memory timeout and an instructions-retired counter.

Parameters:
OPW, 4, opcode width
CNTW, 16, width of retired-instruction counter
TMO, 15, max cycles to wait for MemAck before fault (1..255)

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous active-low reset
Start  in  1  begin execution from IDLE/HALTED (level, sampled)
Stop  in  1  request return to IDLE at next instruction boundary
Opcode  in  OPW  opcode of instruction memory read data
InstrAck  in  1  instruction memory data valid
MemAck  in  1  data memory access complete
InstrReq  out  1  instruction fetch request
IrLoad  out  1  one-cycle pulse: latch instruction register
MemReq  out  1  data memory request
MemWe  out  1  data memory write (valid only with MemReq)
RegWrEn  out  1  register-file write strobe
PcEn  out  1  one-cycle PC update strobe
Busy  out  1  not in IDLE/HALTED/FAULT
Halted  out  1  halt opcode retired
Fault  out  1  memory timeout occurred
Retired  out  CNTW  instructions retired, wraps modulo 2^CNTW

Behaviour:
- Reset (async, Reset_n=0):
  - State IDLE; all outputs 0; Retired=0; latched opcode=0; timeout counter=0.
  - Reset mid-instruction aborts immediately; no partial strobes.
- Outputs are Moore decodes of the state register plus the latched opcode only; no combinational path from inputs to outputs.
- States and transitions:
  - IDLE: Start -> FETCH.
  - FETCH: InstrReq=1. On InstrAck: latch Opcode, IrLoad=1 in the following DECODE cycle, -> DECODE. Without InstrAck, waits indefinitely.
  - DECODE: 1 cycle. Opcode 1011 (halt) -> HALTED; otherwise -> EXEC.
  - EXEC: 1 cycle. Opcode 1000 (ld) or 0111 (str) -> MEM; otherwise -> WB.
  - MEM: MemReq=1, MemWe=1 only for 0111. Timeout counter increments each cycle.
    - MemAck -> WB.
    - Counter reaches TMO without MemAck -> FAULT.
    - MemAck in the same cycle the counter reaches TMO: MemAck wins.
  - WB: 1 cycle.
    - PcEn=1.
    - RegWrEn=1 except for opcodes 0000-0100 (jumps), 0111 (str), 1100 (cmp), 1001 (reserved, executed as nop).
    - Retired increments.
    - Next state: Stop=1 -> IDLE, else -> FETCH.
  - HALTED: Halted=1, PcEn not asserted. Retired increments once on entry; the halt counts as retired. Start -> FETCH and clears Halted.
  - FAULT: Fault=1. Exit only by reset; Start and Stop ignored.
- Stop is honoured only in WB; it never aborts an instruction. Stop asserted in IDLE has no effect.
- Latency with zero-wait acks:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - ld/str: 5 cycles.
  - Each wait cycle on InstrAck or MemAck adds 1.
- Timeout counter clears on entry to MEM.
- Retired wraps from all-ones to 0 silently.
- At most one of RegWrEn, MemWe is asserted in any cycle. PcEn and RegWrEn may coincide only in WB.

Test Plan:
- Reset mid-MEM with MemReq=1 -> next cycle all outputs 0, state IDLE, Retired=0.
- Start=1, opcode 0101 (add), InstrAck/MemAck tied 1 -> InstrReq cycle 1, IrLoad cycle 2, RegWrEn=PcEn=1 cycle 4, Retired=1; back-to-back adds retire one per 4 cycles.
- Opcode 1000 (ld), MemAck delayed 3 cycles -> MemReq=1 for 4 cycles, MemWe=0, RegWrEn in following WB, instruction takes 8 cycles.
- Opcode 0111 (str), MemAck immediate -> MemReq=MemWe=1 one cycle, WB has PcEn=1, RegWrEn=0.
- Opcodes 0010 (jump) and 1100 (cmp) -> PcEn=1, RegWrEn=0.
- Opcode 1011 -> Halted=1, Busy=0, Retired+1; Start -> fetch resumes.
- MemAck never returns on ld with TMO=15 -> Fault=1 after 15 MEM cycles, no PcEn; Start ignored until Reset_n.
- Stop asserted during EXEC -> current instruction completes WB, then IDLE.
- CNTW=4: retire 16 instructions -> Retired returns to 0.
